// File: rtl/lcd_frame_streamer.sv
// Snapshots a ROWS x COLS cell table, scales each cell to a CELL_PX square and
// streams the raster as LCD page/column bytes, optionally re-sending only changed pages.
module lcd_frame_streamer #(
  parameter int ROWS      = 10,
  parameter int COLS      = 10,
  parameter int CELL_PX   = 4,
  parameter int PAGES     = 8,
  parameter int PAGE_COLS = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROWS*COLS-1:0]         table_in,
  input  logic                         start,
  input  logic                         full,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(PAGES)-1:0]     out_page,
  output logic [$clog2(PAGE_COLS)-1:0] out_col,
  output logic [7:0]                   out_data,
  output logic                         out_first,
  output logic                         frame_done,
  output logic [1:0]                   state_dbg
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(PAGE_COLS);
  localparam int IW = $clog2(N);
  localparam int SH = $clog2(CELL_PX);
  localparam int X_LIMIT = COLS * CELL_PX;
  localparam int Y_LIMIT = ROWS * CELL_PX;
  localparam logic [CW-1:0] LAST_COL = CW'(PAGE_COLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t          state;
  logic [N-1:0]    snapshot;
  logic [N-1:0]    last_sent;
  logic            last_valid;
  logic            full_q;
  logic [PAGES-1:0] dirty_q;

  logic [N-1:0]     diff;
  logic [ROWS-1:0]  row_diff;
  logic [PAGES-1:0] dirty_c;
  logic [PW-1:0]    first_page;
  logic [PW-1:0]    next_page;
  logic             has_next;
  logic [PW-1:0]    sel_page;
  logic [CW-1:0]    sel_col;
  logic [7:0]       sel_data;

  assign state_dbg = state;

  // Next byte to present: first byte after LOAD, or the successor of the byte
  // currently on the bus (next column, or column 0 of the next dirty page).
  always_comb begin : next_byte
    int y;
    int x;
    diff = snapshot ^ last_sent;
    for (int r = 0; r < ROWS; r++) row_diff[r] = |diff[r*COLS +: COLS];

    dirty_c = '0;
    if (full_q || !last_valid) begin
      dirty_c = '1;
    end else begin
      for (int p = 0; p < PAGES; p++)
        for (int r = 0; r < ROWS; r++)
          if (row_diff[r] && (r*CELL_PX <= 8*p + 7) && ((r+1)*CELL_PX - 1 >= 8*p))
            dirty_c[p] = 1'b1;
    end

    first_page = '0;
    for (int p = PAGES-1; p >= 0; p--)
      if (dirty_c[p]) first_page = PW'(p);

    next_page = out_page;
    has_next  = 1'b0;
    for (int p = PAGES-1; p >= 0; p--)
      if (dirty_q[p] && (p > int'(out_page))) begin
        next_page = PW'(p);
        has_next  = 1'b1;
      end

    if (state == LOAD) begin
      sel_page = first_page;
      sel_col  = '0;
    end else if (out_col == LAST_COL) begin
      sel_page = next_page;
      sel_col  = '0;
    end else begin
      sel_page = out_page;
      sel_col  = out_col + 1'b1;
    end

    sel_data = '0;
    x = int'(sel_col);
    for (int b = 0; b < 8; b++) begin
      y = int'(sel_page) * 8 + b;
      if (x < X_LIMIT && y < Y_LIMIT)
        sel_data[b] = snapshot[IW'((y >> SH) * COLS + (x >> SH))];
    end
  end

  // Handshake: a byte transfers on a rising edge with out_valid & out_ready;
  // while out_valid & !out_ready every out_* field holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snapshot   <= '0;
      last_sent  <= '0;
      last_valid <= 1'b0;
      full_q     <= 1'b0;
      dirty_q    <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_page   <= '0;
      out_col    <= '0;
      out_data   <= '0;
      out_first  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= table_in;
            full_q   <= full;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          dirty_q <= dirty_c;
          if (dirty_c == '0) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            out_valid <= 1'b1;
            out_page  <= sel_page;
            out_col   <= sel_col;
            out_data  <= sel_data;
            out_first <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_col == LAST_COL && !has_next) begin
              out_valid  <= 1'b0;
              out_page   <= '0;
              out_col    <= '0;
              out_data   <= '0;
              out_first  <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              out_page  <= sel_page;
              out_col   <= sel_col;
              out_data  <= sel_data;
              out_first <= (sel_col == '0);
            end
          end
        end
        default: begin
          last_sent  <= snapshot;
          last_valid <= 1'b1;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Bench for lcd_frame_streamer: frames checked byte-by-byte against a pixel-image
// model that marks a page dirty when its rendered content differs from the last frame.
module tb_lcd_frame_streamer;

  localparam int ROWS = 10, COLS = 10, CELL_PX = 4, PAGES = 8, PAGE_COLS = 128;
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(PAGE_COLS);
  localparam int W  = PW + CW + 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   tbl = '0;
  logic           start = 1'b0;
  logic           full = 1'b0;
  logic           busy;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [PW-1:0]  out_page;
  logic [CW-1:0]  out_col;
  logic [7:0]     out_data;
  logic           out_first;
  logic           frame_done;
  logic [1:0]     state_dbg;

  int chk = 0;
  int err = 0;
  int xfer_cnt = 0;

  logic [W-1:0]   exp_q[$];
  logic [N-1:0]   model_last = '0;
  bit             model_valid = 1'b0;
  bit             prev_stall = 1'b0;
  logic [W:0]     prev_word = '0;

  lcd_frame_streamer #(
    .ROWS(ROWS), .COLS(COLS), .CELL_PX(CELL_PX), .PAGES(PAGES), .PAGE_COLS(PAGE_COLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .table_in(tbl), .start(start), .full(full),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_page(out_page), .out_col(out_col), .out_data(out_data),
    .out_first(out_first), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: pixel at (x,y) of a rendered table image
  function automatic logic pixel(input logic [N-1:0] snap, input int x, input int y);
    if (x >= COLS * CELL_PX || y >= ROWS * CELL_PX) return 1'b0;
    return snap[(y / CELL_PX) * COLS + (x / CELL_PX)];
  endfunction

  function automatic logic [7:0] model_byte(input logic [N-1:0] snap, input int p, input int x);
    logic [7:0] v = '0;
    for (int b = 0; b < 8; b++) v[b] = pixel(snap, x, 8 * p + b);
    return v;
  endfunction

  function automatic logic [N-1:0] rand_tbl();
    logic [127:0] t = {$urandom, $urandom, $urandom, $urandom};
    return t[N-1:0];
  endfunction

  task automatic build_expected(input logic [N-1:0] snap, input bit full_i, output int pages);
    pages = 0;
    for (int p = 0; p < PAGES; p++) begin
      bit dirty = full_i || !model_valid;
      for (int x = 0; x < PAGE_COLS; x++)
        if (model_byte(snap, p, x) != model_byte(model_last, p, x)) dirty = 1'b1;
      if (dirty) begin
        pages++;
        for (int x = 0; x < PAGE_COLS; x++)
          exp_q.push_back({PW'(p), CW'(x), model_byte(snap, p, x), x == 0});
      end
    end
    model_last  = snap;
    model_valid = 1'b1;
  endtask

  // scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({out_valid, out_page, out_col, out_data, out_first}), 32'(prev_word));
      if (out_valid && out_ready) begin
        xfer_cnt++;
        check("queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("byte", 32'({out_page, out_col, out_data, out_first}), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_valid, out_page, out_col, out_data, out_first};
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_page"}, 32'(out_page), 0);
    check({tag, "_col"}, 32'(out_col), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_first"}, out_first, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  // mode: 0 = ready held high, 1 = alternating, 2 = random
  task automatic run_frame(input logic [N-1:0] snap, input bit full_i, input int mode,
                           input bit mid_change);
    int pages;
    int n;
    bit done;
    tbl = snap;
    build_expected(snap, full_i, pages);
    out_ready = 1'b1;
    full = full_i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    full = 1'($urandom_range(0, 1));
    n = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      check("busy_in_frame", busy, 1);
      if (n == 1) check("load_no_valid", out_valid, 0);
      if (n == 2) check("first_valid", out_valid, 32'(pages != 0));
      if (frame_done) begin
        done = 1'b1;
        check("done_no_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      if (mid_change) begin
        if (n == 30) begin
          tbl = rand_tbl();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("frame_done_seen", done, 1);
    if (mode == 0) check("frame_cycles", n, pages * PAGE_COLS + 2);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("done_pulse", frame_done, 0);
  endtask

  initial begin
    logic [N-1:0] s;
    int pages;
    int base;
    int n;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single cell, first frame is full regardless of full=0
    s = '0;
    s[0] = 1'b1;
    run_frame(s, 1'b0, 0, 1'b0);

    // cell (2,5) added: only page 1 differs
    s[25] = 1'b1;
    run_frame(s, 1'b0, 0, 1'b0);

    // unchanged table: no bytes, frame_done at k+2
    run_frame(s, 1'b0, 0, 1'b0);

    // cells (0,0),(1,0), full, alternating ready
    s = '0;
    s[0] = 1'b1;
    s[COLS] = 1'b1;
    run_frame(s, 1'b1, 1, 1'b0);

    // table change and start pulse mid-frame
    run_frame(rand_tbl(), 1'b1, 2, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("no_second_frame", busy, 0);
    end

    // randomized frames with small edits and random flow control
    s = model_last;
    for (int f = 0; f < 6; f++) begin
      int k = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) s = rand_tbl();
      else
        for (int j = 0; j < k; j++) begin
          int i = $urandom_range(0, N - 1);
          s[i] = ~s[i];
        end
      run_frame(s, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0);
    end

    // reset after 100 transfers
    tbl = rand_tbl();
    build_expected(tbl, 1'b1, pages);
    base = xfer_cnt;
    full = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (xfer_cnt < base + 100 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("reached_100_xfers", 32'(xfer_cnt >= base + 100), 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_valid = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(rand_tbl(), 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/lcd_frame_streamer.md
# lcd_frame_streamer

Parametrised successor to the fixed 10x10 game-table-to-LCD converter. It snapshots a ROWS x COLS cell table, scales each cell to a CELL_PX square, and rasterises the result into the LCD's page/column byte format. It streams the bytes to the LCD controller over a valid/ready handshake, with an optional dirty-page mode that re-sends only pages whose content changed. It sits between the game RAM controller and the LCD controller, in the clk_div domain.

## Interface
- ROWS, 10, table rows (row 0 = top of screen)
- COLS, 10, table columns
- CELL_PX, 4, pixels per cell edge; power of two, 1..8
- PAGES, 8, LCD pages (8 pixel rows each)
- PAGE_COLS, 128, columns per page across all chips; COLS*CELL_PX <= PAGE_COLS, ROWS*CELL_PX <= 8*PAGES
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- table_in  in  ROWS*COLS  cell (r,c) at bit r*COLS+c; 1 = pixel block on
- start  in  1  frame request, sampled only in IDLE
- full  in  1  sampled with start: 1 = emit all pages, 0 = emit dirty pages only
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- out_valid  out  1  byte available
- out_ready  in  1  consumer accepts; transfer on out_valid & out_ready
- out_page  out  clog2(PAGES)  page of current byte
- out_col  out  clog2(PAGE_COLS)  column 0..PAGE_COLS-1 of current byte
- out_data  out  8  bit b = pixel row 8*out_page+b (LSB top)
- out_first  out  1  high with col 0 of each emitted page; consumer issues set-page/set-address
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Reset: state IDLE. All outputs are 0. snapshot is 0. last_sent is 0. last_valid is 0.
- FSM: IDLE -> LOAD -> (EMIT | DONE); EMIT -> DONE after the last byte of the last dirty page; DONE -> IDLE.
- IDLE and start=1: snapshot <= table_in; full is latched; go to LOAD. table_in changes after this have no effect on the frame.
- start while not IDLE is ignored and not queued.
- LOAD computes dirty[PAGES-1:0]:
  - all ones if full=1 or last_valid=0;
  - otherwise page p is dirty iff some row r with (snapshot ^ last_sent) nonzero in row r has pixel rows [r*CELL_PX, (r+1)*CELL_PX-1] intersecting [8p, 8p+7].
  - If dirty=0, go to DONE; else go to EMIT at the lowest dirty page, col 0.
- EMIT: for column x, bit b, y = 8*page+b:
  - the bit is snapshot[(y/CELL_PX)*COLS + x/CELL_PX] if x < COLS*CELL_PX and y < ROWS*CELL_PX;
  - otherwise the bit is 0.
  - Divisions are shifts.
- EMIT output ordering: columns 0..PAGE_COLS-1 of each dirty page, pages in ascending order. Clean pages are skipped entirely.
- DONE: last_sent <= snapshot; last_valid <= 1; frame_done=1 for one cycle.
- Reset mid-frame: the frame is aborted immediately and last_valid returns to 0, so the next frame is full.

## Timing
- start sampled high at edge k. LOAD is cycle k+1. The first out_valid is cycle k+2. With dirty=0, frame_done is high in cycle k+2 and busy falls at k+3.
- out_valid, out_page, out_col, out_data and out_first hold stable while out_valid & !out_ready.
- After an accepted byte, the next byte is presented the following cycle with no bubble, including across a page change.
- After the last accepted byte, the next cycle is DONE with out_valid=0 and frame_done=1. IDLE (busy=0) follows one cycle later.
- With out_ready tied 1, a frame of D dirty pages takes exactly D*PAGE_COLS + 2 cycles from start to frame_done.

## Test plan
- Defaults; after reset, only cell(0,0)=1, start, full=0, ready=1:
  - 1024 bytes;
  - page 0 cols 0-3 = 0x0F, all other bytes 0x00;
  - out_first on col 0 of pages 0..7;
  - frame_done at cycle k+1026.
- Then set cell(2,5) (bit 25), full=0:
  - only page 1 emitted (128 bytes);
  - cols 20-23 = 0x0F, rest 0x00.
- Unchanged table, full=0:
  - zero bytes;
  - frame_done in cycle k+2;
  - busy high for cycles k+1..k+2 only.
- Cells (0,0) and (1,0) set, full=1, out_ready alternating 1/0:
  - page 0 cols 0-3 = 0xFF;
  - outputs stable during every stall;
  - 1024 transfers.
- Change table_in mid-frame and pulse start while busy:
  - emitted bytes match the snapshot;
  - no second frame is started.
- Deassert rst_n after 100 transfers:
  - all outputs read 0 while reset is asserted;
  - after release, start with full=0 emits all 8 pages.
